// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler: per-FU rotating-priority issue arbiter with FU busy tracking and FU allocation
// Optional SCHED_DONE_BYPASS_EN lets an FU that is finishing this cycle be granted or allocated at once.
module fu_issue_scheduler #(
  parameter int RS_SIZE = 64,
  parameter int IDX_W   = 6,
  parameter int NUM_FU  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_req,
  output logic [1:0]                alloc_fu,
  input  logic [RS_SIZE-1:0]        req_vec,
  input  logic [2*RS_SIZE-1:0]      req_fu,
  input  logic [NUM_FU-1:0]         fu_done,
  input  logic                      flush,
  output logic [NUM_FU-1:0]         grant_valid,
  output logic [IDX_W*NUM_FU-1:0]   grant_idx,
  output logic [NUM_FU-1:0]         fu_busy
);
  logic [IDX_W-1:0]  prio_ptr [NUM_FU];
  logic [IDX_W-1:0]  win [NUM_FU];
  logic [IDX_W-1:0]  scan;
  logic [1:0]        last_alloc, s1, s2, s3;
  logic [NUM_FU-1:0] idle, elig, found, gnt;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return v == 2'd2 ? 2'd0 : v + 2'd1;
  endfunction

`ifdef SCHED_DONE_BYPASS_EN
  assign idle = ~fu_busy | fu_done;
`else
  assign idle = ~fu_busy;
`endif
  assign elig = idle & ~grant_valid;
  assign gnt  = elig & found;

  always_comb begin
    s1 = inc3(last_alloc);
    s2 = inc3(s1);
    s3 = inc3(s2);
    alloc_fu = idle[s1] ? s1 : idle[s2] ? s2 : idle[s3] ? s3 : s1;
  end

  // First requesting entry at or after prio_ptr[f], wrapping at RS_SIZE
  always_comb begin
    scan = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      found[f] = 1'b0;
      win[f]   = '0;
      for (int k = 0; k < RS_SIZE; k++) begin
        scan = IDX_W'(prio_ptr[f] + IDX_W'(k));
        if (!found[f] && req_vec[scan] && req_fu[2*scan +: 2] == 2'(f)) begin
          found[f] = 1'b1;
          win[f]   = scan;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_valid <= '0;
      grant_idx   <= '0;
      fu_busy     <= '0;
      last_alloc  <= 2'd2;
      for (int f = 0; f < NUM_FU; f++) prio_ptr[f] <= '0;
    end else begin
      if (alloc_req && !flush) last_alloc <= alloc_fu;
      grant_valid <= flush ? '0 : gnt;
      // a same-cycle regrant on a finishing FU keeps it busy with no bubble
      fu_busy     <= flush ? '0 : grant_valid | (fu_busy & (~fu_done | gnt));
      for (int f = 0; f < NUM_FU; f++) begin
        if (gnt[f] && !flush) begin
          grant_idx[IDX_W*f +: IDX_W] <= win[f];
          prio_ptr[f]                 <= win[f] + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb_fu_issue_scheduler: directed scenarios plus randomized traffic checked against a distance-based reference model.
module tb_fu_issue_scheduler;
  logic         clk = 1'b0;
  logic         reset, alloc_req, flush;
  logic [63:0]  req_vec;
  logic [127:0] req_fu;
  logic [2:0]   fu_done;
  logic [1:0]   alloc_fu;
  logic [2:0]   grant_valid, fu_busy;
  logic [17:0]  grant_idx;

  int vectors = 0, miscompares = 0;
  int m_gv[3], m_gi[3], m_busy[3], m_ptr[3], m_last;

  fu_issue_scheduler dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_fu(alloc_fu),
    .req_vec(req_vec), .req_fu(req_fu), .fu_done(fu_done), .flush(flush),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .fu_busy(fu_busy)
  );

  always #5 clk = ~clk;

  function automatic int bypass();
`ifdef SCHED_DONE_BYPASS_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  function automatic int m_idle(int f);
    return (m_busy[f] == 0 || (bypass() != 0 && fu_done[f])) ? 1 : 0;
  endfunction

  // idle FU closest after last_alloc in circular order, else last_alloc+1
  function automatic int m_alloc();
    int best = -1, bd = 4;
    for (int f = 0; f < 3; f++) begin
      int d = (f - m_last - 1 + 6) % 3;
      if (m_idle(f) != 0 && d < bd) begin best = f; bd = d; end
    end
    return best < 0 ? (m_last + 1) % 3 : best;
  endfunction

  // requesting entry with the smallest circular distance from the pointer
  function automatic int m_pick(int f);
    int best = -1, bd = 64;
    for (int e = 0; e < 64; e++) begin
      int d = (e - m_ptr[f] + 64) % 64;
      if (req_vec[e] && int'(req_fu[2*e +: 2]) == f && d < bd) begin best = e; bd = d; end
    end
    return best;
  endfunction

  function automatic logic [2:0] m_gv_vec();
    return {m_gv[2] != 0, m_gv[1] != 0, m_gv[0] != 0};
  endfunction

  function automatic logic [2:0] m_busy_vec();
    return {m_busy[2] != 0, m_busy[1] != 0, m_busy[0] != 0};
  endfunction

  task automatic tick();
    int n_gv[3], n_gi[3], n_busy[3], n_ptr[3], n_last;
    if (!reset) begin
      for (int f = 0; f < 3; f++) begin n_gv[f] = 0; n_gi[f] = 0; n_busy[f] = 0; n_ptr[f] = 0; end
      n_last = 2;
    end else begin
      n_last = (alloc_req && !flush) ? m_alloc() : m_last;
      for (int f = 0; f < 3; f++) begin
        int w = m_pick(f);
        int g = (m_gv[f] == 0 && m_idle(f) != 0 && w >= 0) ? 1 : 0;
        if (flush) begin
          n_gv[f] = 0; n_busy[f] = 0; n_gi[f] = m_gi[f]; n_ptr[f] = m_ptr[f];
        end else begin
          n_gv[f]  = g;
          n_gi[f]  = g != 0 ? w : m_gi[f];
          n_ptr[f] = g != 0 ? (w + 1) % 64 : m_ptr[f];
          if (m_gv[f] != 0) n_busy[f] = 1;
          else if (m_busy[f] != 0 && fu_done[f] && g == 0) n_busy[f] = 0;
          else n_busy[f] = m_busy[f];
        end
      end
    end
    @(posedge clk);
    #1;
    m_gv = n_gv; m_gi = n_gi; m_busy = n_busy; m_ptr = n_ptr; m_last = n_last;
    for (int f = 0; f < 3; f++) if (m_gv[f] != 0) req_vec[m_gi[f]] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; alloc_req = 1'b0; flush = 1'b0; fu_done = '0; req_vec = '0; req_fu = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_grant(input int f, output int idx);
    idx = -1;
    for (int i = 0; i < 10; i++) begin
      fu_done[f] = m_busy[f] != 0;
      tick();
      fu_done = '0;
      if (grant_valid[f]) begin idx = int'(grant_idx[6*f +: 6]); break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_vec = {$urandom, $urandom}; req_fu = {$urandom, $urandom, $urandom, $urandom};
      fu_done = 3'($urandom); flush = 1'($urandom); alloc_req = 1'($urandom);
      tick();
    end
    req_vec = '0; req_fu = '0; fu_done = '0; flush = 1'b0; alloc_req = 1'b0;
    vectors++; if (grant_valid !== 3'b000) begin miscompares++; $display("FAIL reset_gv: got %b want 000", grant_valid); end
    vectors++; if (fu_busy !== 3'b000) begin miscompares++; $display("FAIL reset_busy: got %b want 000", fu_busy); end
    vectors++; if (alloc_fu !== 2'd0) begin miscompares++; $display("FAIL reset_alloc: got %0d want 0", alloc_fu); end
    vectors++; if (grant_idx !== 18'd0) begin miscompares++; $display("FAIL reset_idx: got %h want 0", grant_idx); end
    reset = 1'b1;
  endtask

  task automatic test_rotation();
    int idx;
    int exp_seq[5] = '{5, 9, 40, 63, 0};
    do_reset();
    for (int e = 0; e < 64; e++) req_fu[2*e +: 2] = 2'd1;
    req_vec[5] = 1'b1; req_vec[9] = 1'b1; req_vec[40] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if (n == 3) begin req_vec[63] = 1'b1; req_vec[2] = 1'b1; end
      if (n == 4) req_vec[0] = 1'b1;
      wait_grant(1, idx);
      vectors++;
      if (idx != exp_seq[n]) begin miscompares++; $display("FAIL rotation_%0d: got %0d want %0d", n, idx, exp_seq[n]); end
    end
    req_vec = '0;
  endtask

  task automatic test_parallel();
    do_reset();
    req_fu[5:4] = 2'd0; req_fu[7:6] = 2'd1; req_fu[9:8] = 2'd2;
    req_vec[2] = 1'b1; req_vec[3] = 1'b1; req_vec[4] = 1'b1;
    tick();
    vectors++; if (grant_valid !== 3'b111) begin miscompares++; $display("FAIL parallel_gv: got %b want 111", grant_valid); end
    vectors++;
    if (grant_idx !== {6'd4, 6'd3, 6'd2}) begin miscompares++; $display("FAIL parallel_idx: got %h want %h", grant_idx, {6'd4, 6'd3, 6'd2}); end
  endtask

  task automatic test_alloc();
    do_reset();
    req_vec[10] = 1'b1; req_fu[21:20] = 2'd1; alloc_req = 1'b1;
    vectors++; if (alloc_fu !== 2'd0) begin miscompares++; $display("FAIL alloc_idle: got %0d want 0", alloc_fu); end
    tick();
    alloc_req = 1'b0;
    tick();
    vectors++; if (fu_busy !== 3'b010) begin miscompares++; $display("FAIL alloc_busy1: got %b want 010", fu_busy); end
    vectors++; if (alloc_fu !== 2'd2) begin miscompares++; $display("FAIL alloc_skip: got %0d want 2", alloc_fu); end
    req_vec[20] = 1'b1; req_fu[41:40] = 2'd0; req_vec[21] = 1'b1; req_fu[43:42] = 2'd2;
    tick();
    tick();
    vectors++; if (fu_busy !== 3'b111) begin miscompares++; $display("FAIL alloc_allbusy: got %b want 111", fu_busy); end
    alloc_req = 1'b1;
    vectors++; if (alloc_fu !== 2'd1) begin miscompares++; $display("FAIL alloc_rr1: got %0d want 1", alloc_fu); end
    tick();
    vectors++; if (alloc_fu !== 2'd2) begin miscompares++; $display("FAIL alloc_rr2: got %0d want 2", alloc_fu); end
    tick();
    alloc_req = 1'b0;
    vectors++; if (alloc_fu !== 2'd0) begin miscompares++; $display("FAIL alloc_wrap: got %0d want 0", alloc_fu); end
  endtask

  task automatic test_done_bypass();
    do_reset();
    req_vec[1] = 1'b1;
    tick();
    tick();
    vectors++; if (fu_busy[0] !== 1'b1) begin miscompares++; $display("FAIL done_busy: got %b want 1", fu_busy[0]); end
    req_vec[7] = 1'b1; fu_done[0] = 1'b1;
    tick();
    fu_done = '0;
    if (bypass() != 0) begin
      vectors++; if (grant_valid[0] !== 1'b1 || grant_idx[5:0] !== 6'd7) begin miscompares++; $display("FAIL bypass_grant: got v=%b idx=%0d want v=1 idx=7", grant_valid[0], grant_idx[5:0]); end
      vectors++; if (fu_busy[0] !== 1'b1) begin miscompares++; $display("FAIL bypass_busy: got %b want 1", fu_busy[0]); end
    end else begin
      vectors++; if (grant_valid[0] !== 1'b0 || fu_busy[0] !== 1'b0) begin miscompares++; $display("FAIL bubble: got v=%b busy=%b want 0 0", grant_valid[0], fu_busy[0]); end
      tick();
      vectors++; if (grant_valid[0] !== 1'b1 || grant_idx[5:0] !== 6'd7) begin miscompares++; $display("FAIL done_grant: got v=%b idx=%0d want v=1 idx=7", grant_valid[0], grant_idx[5:0]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    req_vec[2] = 1'b1; req_vec[4] = 1'b1; req_fu[9:8] = 2'd2;
    tick();
    tick();
    req_vec[3] = 1'b1; req_fu[7:6] = 2'd1;
    tick();
    vectors++; if (fu_busy !== 3'b101 || grant_valid !== 3'b010) begin miscompares++; $display("FAIL flush_pre: got busy=%b gv=%b want 101 010", fu_busy, grant_valid); end
    flush = 1'b1; req_vec[6] = 1'b1; req_fu[13:12] = 2'd1;
    tick();
    flush = 1'b0;
    vectors++; if (fu_busy !== 3'b000 || grant_valid !== 3'b000) begin miscompares++; $display("FAIL flush_clear: got busy=%b gv=%b want 000 000", fu_busy, grant_valid); end
    req_vec[2] = 1'b1; req_fu[5:4] = 2'd1;
    tick();
    vectors++; if (grant_valid[1] !== 1'b1 || grant_idx[11:6] !== 6'd6) begin miscompares++; $display("FAIL flush_ptr: got v=%b idx=%0d want v=1 idx=6", grant_valid[1], grant_idx[11:6]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = $urandom_range(0, 99) != 0;
      flush = $urandom_range(0, 39) == 0;
      alloc_req = flush ? 1'b0 : 1'($urandom);
      for (int f = 0; f < 3; f++) fu_done[f] = $urandom_range(0, 2) == 0;
      for (int r = 0; r < 2; r++) begin
        int e = $urandom_range(0, 63);
        int named = 0;
        for (int f = 0; f < 3; f++) if (m_gv[f] != 0 && m_gi[f] == e) named = 1;
        if (!req_vec[e] && named == 0) begin req_vec[e] = 1'b1; req_fu[2*e +: 2] = 2'($urandom_range(0, 2)); end
      end
      vectors++; if (grant_valid !== m_gv_vec()) begin miscompares++; $display("FAIL rand_gv c=%0d: got %b want %b", c, grant_valid, m_gv_vec()); end
      vectors++; if (fu_busy !== m_busy_vec()) begin miscompares++; $display("FAIL rand_busy c=%0d: got %b want %b", c, fu_busy, m_busy_vec()); end
      vectors++; if (int'(alloc_fu) != m_alloc()) begin miscompares++; $display("FAIL rand_alloc c=%0d: got %0d want %0d", c, alloc_fu, m_alloc()); end
      for (int f = 0; f < 3; f++) if (m_gv[f] != 0) begin
        vectors++; if (int'(grant_idx[6*f +: 6]) != m_gi[f]) begin miscompares++; $display("FAIL rand_idx%0d c=%0d: got %0d want %0d", f, c, grant_idx[6*f +: 6], m_gi[f]); end
      end
      tick();
    end
    reset = 1'b1; flush = 1'b0; alloc_req = 1'b0; fu_done = '0;
  endtask

  initial begin
    reset = 1'b0; alloc_req = 1'b0; flush = 1'b0; fu_done = '0; req_vec = '0; req_fu = '0;
    for (int f = 0; f < 3; f++) begin m_gv[f] = 0; m_gi[f] = 0; m_busy[f] = 0; m_ptr[f] = 0; end
    m_last = 2;
    test_reset();
    test_rotation();
    test_parallel();
    test_alloc();
    test_done_bypass();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
